// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port and the memory responder.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: read/write a local array, report misaligned/out-of-range.
// Latency: response valid LATENCY+1 cycles after request acceptance; one request every LATENCY+2 cycles min.
// Backpressure: response is held stable until rsp_ready; no new request is accepted until then.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);
    localparam bit         ZERO_LAT = (LATENCY == 0);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    req_t              live_req;
    req_t              cur_req;
    logic              accept;
    logic              enter_rsp;
    logic              rsp_taken;
    logic              cur_err;
    logic [ADDR_W-1:0] cur_idx;
    logic              commit_wr;

    always_comb begin
        live_req.write = bus.req_write;
        live_req.addr  = bus.req_addr;
        live_req.wdata = bus.req_wdata;
    end

    assign accept    = (state_q == IDLE) && req_ready_q && bus.req_valid;
    assign rsp_taken = (state_q == RESPOND) && bus.rsp_ready;

    // With zero wait states the response is formed on the acceptance edge itself,
    // so the live request has to be used instead of the not-yet-latched copy.
    assign cur_req   = (state_q == IDLE) ? live_req : req_q;
    assign cur_err   = (|cur_req.addr[1:0]) || (|cur_req.addr[31:ADDR_W+2]);
    assign cur_idx   = cur_req.addr[ADDR_W+1:2];
    assign enter_rsp = (accept && ZERO_LAT) || ((state_q == WAIT) && (cnt_q == 4'd1));
    assign commit_wr = enter_rsp && cur_req.write && !cur_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = LAT_LOAD;
                    state_d = ZERO_LAT ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESPOND);
            if (accept) begin
                req_q <= live_req;
            end
            if (enter_rsp) begin
                rsp_err_q   <= cur_err;
                rsp_rdata_q <= (!cur_err && !cur_req.write) ? mem[cur_idx] : '0;
            end else if (rsp_taken) begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    // Array is deliberately not reset; reset forces IDLE so no write can fire during it.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[cur_idx] <= cur_req.wdata;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: LATENCY=2 and LATENCY=0 builds against an array reference model.
// Checks handshake timing, spacing, error decode, backpressure stability and reset behaviour.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(32)) bus2 ();
    mem_responder_if #(.DATA_W(32)) bus0 ();

    mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    // Shared request driver; sel0 routes valid/ready to the LATENCY=0 instance.
    logic        sel0;
    logic        drv_valid, drv_write, drv_rsp_ready;
    logic [31:0] drv_addr, drv_wdata;

    assign bus2.req_valid = drv_valid && !sel0;
    assign bus0.req_valid = drv_valid && sel0;
    assign bus2.rsp_ready = drv_rsp_ready && !sel0;
    assign bus0.rsp_ready = drv_rsp_ready && sel0;
    assign bus2.req_write = drv_write;
    assign bus0.req_write = drv_write;
    assign bus2.req_addr  = drv_addr;
    assign bus0.req_addr  = drv_addr;
    assign bus2.req_wdata = drv_wdata;
    assign bus0.req_wdata = drv_wdata;

    logic        obs_req_ready, obs_rsp_valid, obs_err;
    logic [31:0] obs_rdata;
    assign obs_req_ready = sel0 ? bus0.req_ready : bus2.req_ready;
    assign obs_rsp_valid = sel0 ? bus0.rsp_valid : bus2.rsp_valid;
    assign obs_err       = sel0 ? bus0.rsp_err   : bus2.rsp_err;
    assign obs_rdata     = sel0 ? bus0.rsp_rdata : bus2.rsp_rdata;

    // Reference model: one word array per instance.
    logic [31:0] mdl2 [256];
    logic [31:0] mdl0 [256];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_acc = 0;
    int          prev_hold = 0;
    bit          consec   = 1'b0;
    logic        pend_wr;
    logic [31:0] pend_addr, pend_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_lat();
        return sel0 ? 0 : 2;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        end else if (r == 1) begin
            a = $urandom;
            if (a[31:10] == 22'd0) a[31] = 1'b1;
        end else begin
            a = {22'd0, 8'($urandom), 2'b00};
        end
        return a;
    endfunction

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!obs_req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_idle", 32'(obs_req_ready), 32'd1);
        drv_valid     = 1'b1;
        drv_write     = wr;
        drv_addr      = a;
        drv_wdata     = d;
        drv_rsp_ready = 1'b0;
        @(posedge clk);
        if (consec) check_val("spacing", 32'(cyc - last_acc), 32'(exp_lat() + 2 + prev_hold));
        last_acc   = cyc;
        pend_wr    = wr;
        pend_addr  = a;
        pend_wdata = d;
        @(negedge clk);
        drv_valid     = 1'b0;
        drv_rsp_ready = 1'b0;
        check_val("req_ready_busy", 32'(obs_req_ready), 32'd0);
    endtask

    task automatic collect(input int hold);
        int          n;
        logic        err;
        logic [7:0]  idx;
        logic [31:0] exp_rd;
        n = 0;
        while (!obs_rsp_valid && n < 40) begin
            check_val("req_ready_wait", 32'(obs_req_ready), 32'd0);
            // Noise on the inputs while busy must be ignored.
            drv_valid     = 1'($urandom);
            drv_write     = 1'($urandom);
            drv_addr      = $urandom;
            drv_wdata     = $urandom;
            drv_rsp_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        drv_valid     = 1'b0;
        drv_rsp_ready = 1'b0;
        check_val("latency", 32'(n), 32'(exp_lat()));
        err = (pend_addr[1:0] != 2'b00) || (pend_addr[31:10] != 22'd0);
        idx = pend_addr[9:2];
        if (!err && pend_wr) begin
            if (sel0) mdl0[idx] = pend_wdata;
            else      mdl2[idx] = pend_wdata;
        end
        exp_rd = (err || pend_wr) ? 32'd0 : (sel0 ? mdl0[idx] : mdl2[idx]);
        check_val("rsp_err", 32'(obs_err), 32'(err));
        check_val("rsp_rdata", obs_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(obs_rsp_valid), 32'd1);
            check_val("hold_rdata", obs_rdata, exp_rd);
            check_val("hold_err", 32'(obs_err), 32'(err));
            check_val("hold_req_ready", 32'(obs_req_ready), 32'd0);
        end
        drv_rsp_ready = 1'b1;
        @(negedge clk);
        drv_rsp_ready = 1'b0;
        check_val("post_req_ready", 32'(obs_req_ready), 32'd1);
        check_val("post_rsp_valid", 32'(obs_rsp_valid), 32'd0);
        check_val("post_rdata", obs_rdata, 32'd0);
        check_val("post_err", 32'(obs_err), 32'd0);
        consec    = 1'b1;
        prev_hold = hold;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_val("rst_req_ready", 32'(obs_req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
        check_val("rst_rdata", obs_rdata, 32'd0);
        check_val("rst_err", 32'(obs_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_release_ready", 32'(obs_req_ready), 32'd1);
        consec = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        sel0          = 1'b0;
        drv_valid     = 1'b0;
        drv_write     = 1'b0;
        drv_rsp_ready = 1'b0;
        drv_addr      = 32'd0;
        drv_wdata     = 32'd0;
        repeat (3) @(negedge clk);
        check_val("init_req_ready", 32'(bus2.req_ready), 32'd0);
        check_val("init_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check_val("init_rdata", bus2.rsp_rdata, 32'd0);
        check_val("init_err", 32'(bus2.rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("init_ready2", 32'(bus2.req_ready), 32'd1);
        check_val("init_ready0", 32'(bus0.req_ready), 32'd1);

        // Give every word a known value.
        for (int i = 0; i < 256; i++) begin
            issue(1'b1, {22'd0, 8'(i), 2'b00}, $urandom);
            collect(0);
        end

        issue(1'b1, 32'h10, 32'hDEADBEEF); collect(0);
        issue(1'b0, 32'h10, 32'h0);        collect(0);
        issue(1'b0, 32'h13, 32'h0);        collect(0);
        issue(1'b1, 32'h400, 32'h1);       collect(0);
        issue(1'b0, 32'h0, 32'h0);         collect(0);
        issue(1'b0, 32'h10, 32'h0);        collect(5);

        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom), rand_addr(), $urandom);
            collect($urandom_range(0, 3));
        end

        // Reset during WAIT drops the pending write.
        issue(1'b1, 32'h20, 32'hAAAA); collect(0);
        issue(1'b1, 32'h20, 32'h55);
        do_reset();
        issue(1'b0, 32'h20, 32'h0);    collect(0);

        // Reset during RESPOND keeps the already-committed write.
        issue(1'b1, 32'h30, 32'h13572468);
        repeat (2) @(negedge clk);
        check_val("rspd_valid", 32'(obs_rsp_valid), 32'd1);
        mdl2[12] = 32'h13572468;
        do_reset();
        issue(1'b0, 32'h30, 32'h0);    collect(0);

        // Zero-wait-state instance.
        sel0   = 1'b1;
        consec = 1'b0;
        issue(1'b1, 32'h4, 32'h12345678); collect(0);
        issue(1'b0, 32'h4, 32'h0);        collect(1);
        issue(1'b0, 32'h7, 32'h0);        collect(0);
        issue(1'b1, 32'h800, 32'h9);      collect(0);
        issue(1'b0, 32'h4, 32'h0);        collect(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's unified instruction/data memory port.
- Accepts one word read or write request at a time from the control/datapath side over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns read data or a write acknowledge over a second valid/ready handshake.
- Multi-cycle FSM states that touch memory stall until the response arrives.

Parameters:
- ADDR_W, 8, word-index width; memory holds 2**ADDR_W words.
- DATA_W, 32, data word width.
- LATENCY, 2, wait-state cycles between request acceptance and response (legal 0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes response.
- rsp_rdata  output  DATA_W  read data (0 on write or error).
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- **Reset.** While reset=0, asynchronously: state=IDLE, wait counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared. Memory array is not cleared; its contents are undefined at power-up. After reset deasserts, req_ready=1 from the next edge.
- **States.** IDLE, WAIT, RESPOND.
- **Outputs by state.** All outputs are registered or decoded from state only; there is no combinational path from req_* to req_ready or rsp_*.
  - req_ready=1 only in IDLE.
  - rsp_valid=1 only in RESPOND.
- **IDLE.**
  - Acceptance edge E is a rising edge with req_valid=1 and req_ready=1.
  - At E, latch req_write, req_addr and req_wdata, and load the counter with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESPOND.
  - Inputs presented while not in IDLE are ignored.
- **WAIT.**
  - Counter decrements each edge.
  - On the edge where counter==1, go to RESPOND.
  - WAIT therefore lasts exactly LATENCY cycles.
- **Entering RESPOND (edge E+LATENCY).**
  - err = (addr[1:0]!=0) OR (addr[31:ADDR_W+2]!=0).
  - Read, no error: rsp_rdata <= mem[addr[ADDR_W+1:2]].
  - Write, no error: mem[index] <= wdata; rsp_rdata <= 0.
  - Error: no memory access; rsp_rdata <= 0; rsp_err <= 1.
- **RESPOND.**
  - rsp_valid, rsp_rdata and rsp_err are held stable until an edge with rsp_ready=1.
  - On that edge go to IDLE and clear rsp_err and rsp_rdata.
  - rsp_ready is ignored outside RESPOND.
- **Latency.**
  - rsp_valid is first high in the cycle after edge E+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles: accept, wait, respond, then IDLE.
  - There is no pipelining.
- **Write commit.** A write is committed exactly once, on RESPOND entry.
- **Reset during WAIT.** Reset asserted during WAIT drops the request; no write occurs.
- **Reset during RESPOND.** Reset asserted during RESPOND discards the response; a write that has already committed stays committed.
- **Same address write then read.** A read returns the value from the most recent committed write to that address.

Test Plan:
- **Write then read.** Reset, then write addr 0x10, data 0xDEADBEEF, with rsp_ready=1. Expect rsp_valid high 3 cycles after acceptance, rsp_err=0. Then read 0x10: rsp_rdata=0xDEADBEEF, rsp_err=0.
- **Latency and spacing.** Issue reads continuously with rsp_ready=1. Expect req_ready low for 3 cycles after each acceptance, and a new acceptance every 4 cycles at LATENCY=2.
- **Error cases.**
  - Read 0x13 (misaligned) gives rsp_err=1, rsp_rdata=0.
  - Write 0x400 (out of range, ADDR_W=8) with data 0x1 gives rsp_err=1.
  - A following read of 0x0 must return its prior value, with no aliasing of the dropped write.
- **Response backpressure.** Hold rsp_ready=0 for 5 cycles in RESPOND. Expect rsp_valid, rsp_rdata and rsp_err stable, and req_ready=0. Raise rsp_ready; expect IDLE and req_ready=1 the next cycle.
- **Reset in WAIT.** Write 0x20, 0x55 and assert reset=0 during WAIT. Expect all outputs 0 immediately. After release, a read of 0x20 returns its pre-write value (the bench initialises it to 0xAAAA beforehand).
- **LATENCY=0 build.** Read 0x4 after writing 0x12345678. Expect rsp_valid in the cycle immediately after acceptance, rsp_rdata=0x12345678.
